// File: rtl/dmem_arbiter.sv
// Two-port front end for the single data memory: core MEM stage and debug loader
// share it round-robin, one access at a time, with byte-lane steering.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: a port raises req with its fields and keeps req high until its
    // completion cycle (core_stall low for the core, dbg_ack for debug); the
    // fields are sampled once, at grant, and ignored afterwards.
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [1:0]        core_size,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [1:0]        dbg_size,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err_misaligned,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic [2:0]        cnt;
    logic              last_dbg;
    logic              grant_dbg;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [1:0]        buf_size;
    logic [31:0]       buf_wdata;
    logic              buf_mis;

    logic              req_any;
    logic              sel_dbg;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic [31:0]       sel_wdata;
    logic              sel_mis;
    logic [31:0]       rd_lane;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = 4'b0011 << a;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   lane_wdata = {4{w[7:0]}};
            2'b01:   lane_wdata = {2{w[15:0]}};
            default: lane_wdata = w;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (size)
            2'b00:   lane_rdata = {24'd0, sh[7:0]};
            2'b01:   lane_rdata = {16'd0, sh[15:0]};
            default: lane_rdata = sh;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    // Debug wins only when alone or when the core was served last.
    assign req_any   = core_req | dbg_req;
    assign sel_dbg   = dbg_req & (~core_req | ~last_dbg);
    assign sel_we    = sel_dbg ? dbg_we    : core_we;
    assign sel_addr  = sel_dbg ? dbg_addr  : core_addr;
    assign sel_size  = sel_dbg ? dbg_size  : core_size;
    assign sel_wdata = sel_dbg ? dbg_wdata : core_wdata;
    assign sel_mis   = is_misaligned(sel_size, sel_addr[1:0]);
    assign rd_lane   = lane_rdata(buf_size, buf_addr[1:0], mem_rdata);
    assign fsm_state = state;

    always_comb begin
        state_nx       = state;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_be         = 4'b0000;
        mem_wdata      = 32'd0;
        dbg_ack        = 1'b0;
        err_misaligned = 1'b0;
        core_stall     = core_req;
        case (state)
            IDLE: begin
                if (req_any) state_nx = sel_mis ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = buf_we;
                mem_addr  = {buf_addr[ADDR_W-1:2], 2'b00};
                mem_be    = lane_be(buf_size, buf_addr[1:0]);
                mem_wdata = lane_wdata(buf_size, buf_wdata);
                state_nx  = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0) state_nx = DONE;
            end
            DONE: begin
                core_stall     = core_req & grant_dbg;
                dbg_ack        = grant_dbg;
                err_misaligned = buf_mis;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            last_dbg   <= 1'b1;
            grant_dbg  <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_size   <= 2'b00;
            buf_wdata  <= 32'd0;
            buf_mis    <= 1'b0;
            core_rdata <= 32'd0;
            dbg_rdata  <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_dbg <= sel_dbg;
                        buf_we    <= sel_we;
                        buf_addr  <= sel_addr;
                        buf_size  <= sel_size;
                        buf_wdata <= sel_wdata;
                        buf_mis   <= sel_mis;
                        // A misaligned access skips WAIT, so it settles arbitration here.
                        if (sel_mis) begin
                            last_dbg <= sel_dbg;
                            if (sel_dbg) dbg_rdata  <= 32'd0;
                            else         core_rdata <= 32'd0;
                        end
                    end
                end
                ACCESS: cnt <= CNT_INIT;
                WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        if (grant_dbg) dbg_rdata  <= rd_lane;
                        else           core_rdata <= rd_lane;
                        last_dbg <= grant_dbg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
